// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, frames
// 11-bit serial bytes and folds E0/F0 prefixes into one 11-bit key event.
module ps2_scancode_rx #(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 14000
) (
  input  logic        CLK_14M,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] PS2_Key,
  output logic        frame_err
);

  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      clk_s;
  logic [1:0]      dat_s;
  logic            filt_clk;
  logic            filt_prev;
  logic [FW-1:0]   filt_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            ext_q;
  logic            brk_q;
  logic            fall;
  logic            timeout;
  logic            shift_en;
  logic            par_en;
  logic            clr_cnt;
  logic            tmo_evt;
  logic            stop_evt;
  logic            frame_ok;
  logic            byte_good;
  logic            special;

  assign fall      = filt_prev & ~filt_clk;
  assign timeout   = (state_q != IDLE) && (tmo_cnt == TMO_LIM);
  assign frame_ok  = dat_s[1] & (^{shreg, par_bit});
  assign byte_good = stop_evt & frame_ok;
  assign special   = shreg inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
    end
  end

  // Filtered clock follows the synchronized clock only after FILT_LEN
  // consecutive differing samples; any agreeing sample restarts the count.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_s[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state_q == IDLE || fall) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LIM) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout is tested before the edge so it wins when both coincide.
  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    par_en   = 1'b0;
    clr_cnt  = 1'b0;
    tmo_evt  = 1'b0;
    stop_evt = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      tmo_evt = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s[1]) begin
            state_d = DATA;
            clr_cnt = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_en  = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          stop_evt = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (clr_cnt) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shreg <= {dat_s[1], shreg[7:1]};
      end
      if (par_en) begin
        par_bit <= dat_s[1];
      end
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      PS2_Key   <= '0;
      frame_err <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      frame_err <= tmo_evt | (stop_evt & ~frame_ok);
      if (tmo_evt) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_good) begin
        if (shreg == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (special) begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end else begin
          PS2_Key <= {~PS2_Key[10], ~brk_q, ext_q, shreg};
          ext_q   <= 1'b0;
          brk_q   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

  localparam int FL   = 8;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic        CLK_14M  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] PS2_Key;
  logic        frame_err;

  int errors = 0;
  int checks = 0;

  logic [10:0] m_key = '0;
  bit          m_ext = 1'b0;
  bit          m_brk = 1'b0;
  int          m_errs = 0;
  int          m_upd  = 0;

  int          mon_errs  = 0;
  int          mon_upd   = 0;
  int          mon_wide  = 0;
  int          mon_notog = 0;
  logic [10:0] prev_key  = '0;
  logic        prev_err  = 1'b0;
  int          lat       = -1;

  ps2_scancode_rx #(.FILT_LEN(FL), .TIMEOUT(TO)) dut (
    .CLK_14M  (CLK_14M),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .PS2_Key  (PS2_Key),
    .frame_err(frame_err)
  );

  always #5 CLK_14M = ~CLK_14M;

  always @(negedge CLK_14M) begin
    if (!reset_n) begin
      prev_key = PS2_Key;
      prev_err = 1'b0;
    end else begin
      if (frame_err === 1'b1) begin
        mon_errs++;
        if (prev_err) mon_wide++;
      end
      if (PS2_Key !== prev_key) begin
        mon_upd++;
        if (PS2_Key[10] === prev_key[10]) mon_notog++;
      end
      prev_key = PS2_Key;
      prev_err = frame_err;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_14M);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit pflip, input bit stopv);
    logic par;
    par = ~(^b) ^ pflip;
    return {stopv, par, b, 1'b0};
  endfunction

  function automatic bit is_special(input logic [7:0] b);
    return b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  // glitch_at: -1 none, -2 short low pulse on an idle line before the start
  // bit, k >= 0 short low pulse in the high phase after bit k.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
    logic [10:0] k0;
    if (glitch_at == -2) begin
      ps2_data = 1'b0;
      cyc(4);
      ps2_clk = 1'b0;
      cyc(FL - 3);
      ps2_clk = 1'b1;
      cyc(HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      k0 = PS2_Key;
      lat = -1;
      for (int c = 1; c <= HALF; c++) begin
        cyc(1);
        if (lat < 0 && PS2_Key !== k0) lat = c;
      end
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        cyc(6);
        ps2_clk = 1'b0;
        cyc(FL - 3);
        ps2_clk = 1'b1;
        cyc(6);
      end
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit pflip, input bit stopv);
    if (pflip || !stopv) begin
      m_errs++;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (is_special(b)) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_upd++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pflip = 1'b0, input bit stopv = 1'b1,
                            input int glitch_at = -1);
    send_bits(frame_bits(b, pflip, stopv), 11, glitch_at);
    model_frame(b, pflip, stopv);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cyc(5);
    checks++;
    if (PS2_Key !== 11'h000) begin
      errors++;
      $display("FAIL reset_key: got %h expected %h", PS2_Key, 11'h000);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", frame_err);
    end
    reset_n = 1'b1;
    cyc(5);
  endtask

  task automatic test_basic;
    send_frame(8'h1C);
    checks++;
    if (PS2_Key !== 11'h61C) begin
      errors++;
      $display("FAIL basic_key: got %h expected %h", PS2_Key, 11'h61C);
    end
    checks++;
    if (lat < FL + 1 || lat > FL + 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles expected %0d..%0d", lat, FL + 1, FL + 4);
    end
    checks++;
    if (mon_errs !== 0) begin
      errors++;
      $display("FAIL basic_err: got %0d pulses expected 0", mon_errs);
    end
  endtask

  task automatic test_break;
    int u0;
    u0 = mon_upd;
    send_frame(8'hF0);
    checks++;
    if (mon_upd !== u0 || PS2_Key !== 11'h61C) begin
      errors++;
      $display("FAIL break_prefix: got key %h upd %0d expected key %h upd %0d", PS2_Key, mon_upd, 11'h61C, u0);
    end
    send_frame(8'h1C);
    checks++;
    if (PS2_Key !== 11'h01C || mon_upd !== u0 + 1) begin
      errors++;
      $display("FAIL break_key: got key %h upd %0d expected key %h upd %0d", PS2_Key, mon_upd, 11'h01C, u0 + 1);
    end
  endtask

  task automatic test_ext;
    logic t0;
    t0 = PS2_Key[10];
    send_frame(8'hE0);
    send_frame(8'h75);
    checks++;
    if (PS2_Key[9:0] !== 10'h375 || PS2_Key[10] !== ~t0) begin
      errors++;
      $display("FAIL ext_make: got %h expected %h", PS2_Key, {~t0, 10'h375});
    end
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    checks++;
    if (PS2_Key[9:0] !== 10'h175 || PS2_Key[10] !== t0) begin
      errors++;
      $display("FAIL ext_break: got %h expected %h", PS2_Key, {t0, 10'h175});
    end
  endtask

  task automatic test_frame_errors;
    logic [10:0] k0;
    int e0;
    k0 = PS2_Key;
    e0 = mon_errs;
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++;
    if (mon_errs !== e0 + 1 || PS2_Key !== k0) begin
      errors++;
      $display("FAIL parity_err: got key %h errs %0d expected key %h errs %0d", PS2_Key, mon_errs, k0, e0 + 1);
    end
    send_frame(8'h1C);
    checks++;
    if (PS2_Key !== m_key) begin
      errors++;
      $display("FAIL after_parity: got %h expected %h", PS2_Key, m_key);
    end
    send_frame(8'hE0);
    send_frame(8'h2B, 1'b0, 1'b0);
    checks++;
    if (mon_errs !== e0 + 2 || PS2_Key !== m_key) begin
      errors++;
      $display("FAIL stop_err: got key %h errs %0d expected key %h errs %0d", PS2_Key, mon_errs, m_key, e0 + 2);
    end
    send_frame(8'h6B);
    checks++;
    if (PS2_Key !== m_key) begin
      errors++;
      $display("FAIL flag_kept: got %h expected %h", PS2_Key, m_key);
    end
  endtask

  task automatic test_timeout;
    logic [10:0] k0;
    int e0;
    send_frame(8'hE0);
    k0 = PS2_Key;
    e0 = mon_errs;
    send_bits(11'b000_1010_0100, 5, -1);
    cyc(TO + 10);
    m_errs++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    checks++;
    if (mon_errs !== e0 + 1 || PS2_Key !== k0) begin
      errors++;
      $display("FAIL timeout: got key %h errs %0d expected key %h errs %0d", PS2_Key, mon_errs, k0, e0 + 1);
    end
    send_frame(8'h75);
    checks++;
    if (PS2_Key !== m_key || PS2_Key[8] !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: got %h expected %h", PS2_Key, m_key);
    end
  endtask

  task automatic test_glitch;
    send_frame(8'h1C, 1'b0, 1'b1, -2);
    checks++;
    if (PS2_Key !== m_key) begin
      errors++;
      $display("FAIL glitch_idle: got %h expected %h", PS2_Key, m_key);
    end
    send_frame(8'h2A, 1'b0, 1'b1, 4);
    checks++;
    if (PS2_Key !== m_key) begin
      errors++;
      $display("FAIL glitch_mid: got %h expected %h", PS2_Key, m_key);
    end
  endtask

  task automatic test_reset_midframe;
    int e0;
    int u0;
    e0 = mon_errs;
    u0 = mon_upd;
    send_bits(frame_bits(8'h33, 1'b0, 1'b1), 6, -1);
    reset_n = 1'b0;
    cyc(3);
    m_key = '0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    checks++;
    if (PS2_Key !== 11'h000 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got key %h err %b expected key 000 err 0", PS2_Key, frame_err);
    end
    reset_n = 1'b1;
    cyc(3);
    send_bits(11'h001, 1, -1);
    send_frame(8'h1C);
    checks++;
    if (PS2_Key !== 11'h61C || mon_errs !== e0 || mon_upd !== u0 + 1) begin
      errors++;
      $display("FAIL after_reset: got key %h errs %0d upd %0d expected key %h errs %0d upd %0d",
               PS2_Key, mon_errs, mon_upd, 11'h61C, e0, u0 + 1);
    end
  endtask

  task automatic test_random;
    logic [7:0] specials [7];
    logic [7:0] b;
    bit pflip;
    bit stopv;
    int sel;
    specials = '{8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      else if (sel == 2) b = specials[$urandom_range(0, 6)];
      else b = 8'($urandom);
      pflip = ($urandom_range(0, 9) == 0);
      stopv = ($urandom_range(0, 11) != 0);
      send_frame(b, pflip, stopv);
      checks++;
      if (PS2_Key !== m_key || mon_errs !== m_errs) begin
        errors++;
        $display("FAIL random_%0d byte %h: got key %h errs %0d expected key %h errs %0d",
                 n, b, PS2_Key, mon_errs, m_key, m_errs);
      end
    end
  endtask

  task automatic test_totals;
    checks++;
    if (mon_upd !== m_upd) begin
      errors++;
      $display("FAIL update_count: got %0d expected %0d", mon_upd, m_upd);
    end
    checks++;
    if (mon_notog !== 0) begin
      errors++;
      $display("FAIL toggle: got %0d updates without toggle expected 0", mon_notog);
    end
    checks++;
    if (mon_wide !== 0) begin
      errors++;
      $display("FAIL err_width: got %0d multi-cycle pulses expected 0", mon_wide);
    end
    checks++;
    if (mon_errs !== m_errs) begin
      errors++;
      $display("FAIL err_count: got %0d expected %0d", mon_errs, m_errs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_ext();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random();
    test_totals();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
